// File: rtl/mcpu_iomap_if.sv
// mcpu_iomap_if: main CPU I/O bus between the CPU wrapper (master) and the
// I/O-space decoder (slave). Carries decoded strobes, address, write data and
// the registered read data / read-select returned to the CPU data-in mux.
interface mcpu_iomap_if;
  logic [15:0] mcpu_ab;
  logic [7:0]  mcpu_dout;
  logic        mcpu_wr;
  logic        mcpu_rd;
  logic        mcpu_io;
  logic        mcpu_m1;
  logic [7:0]  io_dout;
  logic        io_sel;

  modport master (
    output mcpu_ab, mcpu_dout, mcpu_wr, mcpu_rd, mcpu_io, mcpu_m1,
    input  io_dout, io_sel
  );

  modport slave (
    input  mcpu_ab, mcpu_dout, mcpu_wr, mcpu_rd, mcpu_io, mcpu_m1,
    output io_dout, io_sel
  );
endinterface

// File: rtl/mcpu_iomap.sv
// mcpu_iomap: Z80 I/O-space decoder for the main CPU.
//   - read map 0x00..0x05 (inputs + status), everything else reads 0xFF
//   - write map 0x10 sound latch, 0x11 control reg, 0x12 watchdog kick
//   - main-to-sound command latch with full/overrun handshake
//   - optional frame watchdog, enabled by defining MCPU_IOMAP_WDOG_EN
module mcpu_iomap #(
  parameter logic [7:0] WDOG_FRAMES  = 8'd60,
  parameter logic [7:0] WDOG_RST_LEN = 8'd32
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  mcpu_iomap_if.slave      bus,
  input  logic             vb,
  input  logic [7:0]       p1,
  input  logic [7:0]       p2,
  input  logic [7:0]       system,
  input  logic [7:0]       dsw1,
  input  logic [7:0]       dsw2,
  output logic [7:0]       snd_latch,
  output logic             snd_full,
  input  logic             snd_rd,
  output logic             flip,
  output logic             coin_cnt1,
  output logic             coin_cnt2,
  output logic             wdog_reset
);

  localparam logic [7:0] A_P1    = 8'h00;
  localparam logic [7:0] A_P2    = 8'h01;
  localparam logic [7:0] A_SYS   = 8'h02;
  localparam logic [7:0] A_DSW1  = 8'h03;
  localparam logic [7:0] A_DSW2  = 8'h04;
  localparam logic [7:0] A_STAT  = 8'h05;
  localparam logic [7:0] A_SND   = 8'h10;
  localparam logic [7:0] A_CTRL  = 8'h11;
  localparam logic [7:0] A_KICK  = 8'h12;

  logic [7:0] addr;
  logic       ioc, wr_cond, rd_cond;

  // Interrupt-acknowledge cycles (io & m1) are never decoded.
  assign addr    = bus.mcpu_ab[7:0];
  assign ioc     = bus.mcpu_io & ~bus.mcpu_m1;
  assign wr_cond = ioc & bus.mcpu_wr;
  assign rd_cond = ioc & bus.mcpu_rd;

  logic wr_q, rd_q, wr_arm, rd_arm;
  logic wr_stb, stat_stb;
  logic snd_rd_q, snd_rd_stb;

  // Edge detectors producing registered one-cycle strobes. The arm flags keep
  // a strobe from firing for a cycle already in progress when reset releases:
  // the condition must be seen low once before a rising edge counts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_arm     <= 1'b0;
      rd_arm     <= 1'b0;
      wr_stb     <= 1'b0;
      stat_stb   <= 1'b0;
      snd_rd_q   <= 1'b0;
      snd_rd_stb <= 1'b0;
    end else begin
      wr_q       <= wr_cond;
      rd_q       <= rd_cond;
      wr_arm     <= wr_arm | ~wr_cond;
      rd_arm     <= rd_arm | ~rd_cond;
      wr_stb     <= wr_cond & ~wr_q & wr_arm;
      stat_stb   <= rd_cond & ~rd_q & rd_arm & (addr == A_STAT);
      snd_rd_q   <= snd_rd;
      snd_rd_stb <= snd_rd & ~snd_rd_q;
    end
  end

  logic wr_latch, wr_ctrl;
  assign wr_latch = wr_stb & (addr == A_SND);
  assign wr_ctrl  = wr_stb & (addr == A_CTRL);

  // A status read clears the sticky bits only once the read cycle ends, so the
  // CPU samples a stable value for the whole cycle.
  logic clr_pend, stat_clr;
  assign stat_clr = clr_pend & ~rd_cond;

  // Deferred status-clear tracking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        clr_pend <= 1'b0;
    else if (stat_stb)   clr_pend <= 1'b1;
    else if (!rd_cond)   clr_pend <= 1'b0;
  end

  logic overrun;

  // Sound command latch: a write beats a same-cycle consume, and a write onto
  // an unread command flags overrun unless the consume lands in that cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      snd_latch <= 8'h00;
      snd_full  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_latch) begin
        snd_latch <= bus.mcpu_dout;
        snd_full  <= 1'b1;
      end else if (snd_rd_stb) begin
        snd_full  <= 1'b0;
      end
      if (wr_latch && snd_full && !snd_rd_stb) overrun <= 1'b1;
      else if (stat_clr)                       overrun <= 1'b0;
    end
  end

  // Control register: flip and coin counters, upper data bits ignored.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      flip      <= 1'b0;
      coin_cnt1 <= 1'b0;
      coin_cnt2 <= 1'b0;
    end else if (wr_ctrl) begin
      flip      <= bus.mcpu_dout[0];
      coin_cnt1 <= bus.mcpu_dout[1];
      coin_cnt2 <= bus.mcpu_dout[2];
    end
  end

  logic wdog_fired;

`ifdef MCPU_IOMAP_WDOG_EN
  logic       wr_kick, vb_q, vb_edge, wdog_fire;
  logic [7:0] wd_cnt, rst_cnt;

  assign wr_kick   = wr_stb & (addr == A_KICK);
  assign vb_edge   = vb & ~vb_q;
  // Frames seen during the reset pulse are ignored; a kick beats a vb edge.
  assign wdog_fire = vb_edge & ~wdog_reset & ~wr_kick &
                     (wd_cnt == WDOG_FRAMES - 8'd1);

  // Frame counter: counts vblank rising edges since the last kick.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vb_q   <= 1'b0;
      wd_cnt <= 8'h00;
    end else begin
      vb_q <= vb;
      if (wr_kick)                      wd_cnt <= 8'h00;
      else if (vb_edge && !wdog_reset)  wd_cnt <= wdog_fire ? 8'h00 : wd_cnt + 8'd1;
    end
  end

  // Reset pulse: high for exactly WDOG_RST_LEN cycles after the fire.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wdog_reset <= 1'b0;
      rst_cnt    <= 8'h00;
      wdog_fired <= 1'b0;
    end else begin
      if (wdog_fire) begin
        wdog_reset <= 1'b1;
        rst_cnt    <= WDOG_RST_LEN - 8'd1;
      end else if (wdog_reset) begin
        if (rst_cnt == 8'h00) wdog_reset <= 1'b0;
        else                  rst_cnt    <= rst_cnt - 8'd1;
      end
      if (wdog_fire)     wdog_fired <= 1'b1;
      else if (stat_clr) wdog_fired <= 1'b0;
    end
  end
`else
  assign wdog_reset = 1'b0;
  assign wdog_fired = 1'b0;
  logic unused_wdog;
  assign unused_wdog = &{1'b0, vb, WDOG_FRAMES, WDOG_RST_LEN};
`endif

  logic unused_ab;
  assign unused_ab = &{1'b0, bus.mcpu_ab[15:8]};

  logic [7:0] rd_mux;

  // Read data mux on the low address byte.
  always_comb begin
    rd_mux = 8'hFF;
    case (addr)
      A_P1:    rd_mux = p1;
      A_P2:    rd_mux = p2;
      A_SYS:   rd_mux = system;
      A_DSW1:  rd_mux = dsw1;
      A_DSW2:  rd_mux = dsw2;
      A_STAT:  rd_mux = {5'b0, wdog_fired, overrun, snd_full};
      default: rd_mux = 8'hFF;
    endcase
  end

  // Registered read path: io_dout tracks the mux during a read, else holds.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.io_sel  <= 1'b0;
      bus.io_dout <= 8'hFF;
    end else begin
      bus.io_sel <= rd_cond;
      if (rd_cond) bus.io_dout <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mcpu_iomap.sv
// tb_mcpu_iomap: directed self-checking bench for mcpu_iomap.
// Watchdog scenarios follow MCPU_IOMAP_WDOG_EN, matching the design build.
module tb_mcpu_iomap;
  logic       clk_sys, reset_n, vb, snd_rd;
  logic [7:0] p1, p2, system, dsw1, dsw2;
  logic [7:0] snd_latch;
  logic       snd_full, flip, coin_cnt1, coin_cnt2, wdog_reset;
  int         total, bad;

  mcpu_iomap_if bus ();

  mcpu_iomap #(.WDOG_FRAMES(8'd3), .WDOG_RST_LEN(8'd32)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .vb         (vb),
    .p1         (p1),
    .p2         (p2),
    .system     (system),
    .dsw1       (dsw1),
    .dsw2       (dsw2),
    .snd_latch  (snd_latch),
    .snd_full   (snd_full),
    .snd_rd     (snd_rd),
    .flip       (flip),
    .coin_cnt1  (coin_cnt1),
    .coin_cnt2  (coin_cnt2),
    .wdog_reset (wdog_reset)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // advance n edges, land 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_idle();
    bus.mcpu_ab = 16'h0000; bus.mcpu_dout = 8'h00;
    bus.mcpu_wr = 1'b0; bus.mcpu_rd = 1'b0; bus.mcpu_io = 1'b0; bus.mcpu_m1 = 1'b0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bus.mcpu_ab = a; bus.mcpu_dout = d; bus.mcpu_io = 1'b1; bus.mcpu_wr = 1'b1;
    tick(3);
    bus.mcpu_wr = 1'b0; bus.mcpu_io = 1'b0;
    tick(2);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d, output logic sel);
    bus.mcpu_ab = a; bus.mcpu_io = 1'b1; bus.mcpu_rd = 1'b1;
    tick(3);
    d = bus.io_dout; sel = bus.io_sel;
    bus.mcpu_rd = 1'b0; bus.mcpu_io = 1'b0;
    tick(2);
  endtask

  task automatic vb_pulse();
    vb = 1'b1; tick(2); vb = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vb = 1'b0; snd_rd = 1'b0;
    bus_idle();
    // a control write already in progress across reset release
    bus.mcpu_ab = 16'h0011; bus.mcpu_dout = 8'h07; bus.mcpu_io = 1'b1; bus.mcpu_wr = 1'b1;
    tick(2);
    total++; if (bus.io_dout !== 8'hFF) begin bad++; $display("FAIL reset_io_dout got=%h exp=ff", bus.io_dout); end
    total++; if (bus.io_sel !== 1'b0) begin bad++; $display("FAIL reset_io_sel got=%b exp=0", bus.io_sel); end
    total++; if ({snd_latch, snd_full} !== 9'h000) begin bad++; $display("FAIL reset_snd got=%h/%b exp=00/0", snd_latch, snd_full); end
    total++; if ({flip, coin_cnt1, coin_cnt2, wdog_reset} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {flip, coin_cnt1, coin_cnt2, wdog_reset}); end
    reset_n = 1'b1;
    tick(4);
    total++; if ({flip, coin_cnt1, coin_cnt2} !== 3'b000) begin bad++; $display("FAIL midreset_no_strobe got=%b exp=000", {flip, coin_cnt1, coin_cnt2}); end
    bus.mcpu_wr = 1'b0; tick(1);
    bus.mcpu_wr = 1'b1; tick(3);
    total++; if ({flip, coin_cnt1, coin_cnt2} !== 3'b111) begin bad++; $display("FAIL midreset_rewrite got=%b exp=111", {flip, coin_cnt1, coin_cnt2}); end
    bus_idle(); tick(2);
    io_write(16'h0011, 8'h00);
  endtask

  task automatic test_read_map();
    logic [7:0] d; logic s;
    logic [7:0] exp_d [7];
    logic [15:0] adr [7];
    p1 = 8'hFE; p2 = 8'hFD; system = 8'hFB; dsw1 = 8'hF7; dsw2 = 8'h3C;
    adr   = '{16'h0000, 16'hAB01, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h007F};
    exp_d = '{8'hFE,    8'hFD,    8'hFB,    8'hF7,    8'h3C,    8'h00,    8'hFF};
    for (int i = 0; i < 7; i++) begin
      io_read(adr[i], d, s);
      total++; if (d !== exp_d[i]) begin bad++; $display("FAIL read_%h got=%h exp=%h", adr[i], d, exp_d[i]); end
      total++; if (s !== 1'b1) begin bad++; $display("FAIL io_sel_%h got=%b exp=1", adr[i], s); end
    end
    // interrupt acknowledge: not decoded, io_dout holds last value
    bus.mcpu_ab = 16'h0000; bus.mcpu_io = 1'b1; bus.mcpu_m1 = 1'b1; bus.mcpu_rd = 1'b1;
    tick(3);
    total++; if (bus.io_sel !== 1'b0) begin bad++; $display("FAIL inta_io_sel got=%b exp=0", bus.io_sel); end
    total++; if (bus.io_dout !== 8'hFF) begin bad++; $display("FAIL inta_io_dout got=%h exp=ff", bus.io_dout); end
    bus_idle(); tick(2);
  endtask

  task automatic test_snd_latch();
    logic [7:0] d; logic s;
    bus.mcpu_ab = 16'h0010; bus.mcpu_dout = 8'h5A; bus.mcpu_io = 1'b1; bus.mcpu_wr = 1'b1;
    tick(1);
    total++; if (snd_full !== 1'b0) begin bad++; $display("FAIL snd_full_early got=%b exp=0", snd_full); end
    tick(1);
    total++; if ({snd_latch, snd_full} !== {8'h5A, 1'b1}) begin bad++; $display("FAIL snd_write got=%h/%b exp=5a/1", snd_latch, snd_full); end
    bus_idle(); tick(2);
    snd_rd = 1'b1; tick(1);
    total++; if (snd_full !== 1'b1) begin bad++; $display("FAIL snd_rd_1cyc got=%b exp=1", snd_full); end
    tick(1);
    total++; if (snd_full !== 1'b0) begin bad++; $display("FAIL snd_rd_2cyc got=%b exp=0", snd_full); end
    snd_rd = 1'b0; tick(2);
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL snd_status_clear got=%h exp=00", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d; logic s;
    io_write(16'h0010, 8'h01);
    io_write(16'h0010, 8'h02);
    total++; if (snd_latch !== 8'h02) begin bad++; $display("FAIL overrun_latch got=%h exp=02", snd_latch); end
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL overrun_status got=%h exp=03", d); end
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL overrun_cleared got=%h exp=01", d); end
    snd_rd = 1'b1; tick(3); snd_rd = 1'b0; tick(2);
    total++; if (snd_full !== 1'b0) begin bad++; $display("FAIL overrun_consume got=%b exp=0", snd_full); end
  endtask

  task automatic test_collision();
    logic [7:0] d; logic s;
    io_write(16'h0010, 8'h11);
    // write strobe and snd_rd edge land in the same cycle
    bus.mcpu_ab = 16'h0010; bus.mcpu_dout = 8'h22; bus.mcpu_io = 1'b1; bus.mcpu_wr = 1'b1;
    snd_rd = 1'b1;
    tick(3);
    bus_idle(); tick(2);
    total++; if ({snd_latch, snd_full} !== {8'h22, 1'b1}) begin bad++; $display("FAIL collide_latch got=%h/%b exp=22/1", snd_latch, snd_full); end
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL collide_status got=%h exp=01", d); end
    snd_rd = 1'b0; tick(2); snd_rd = 1'b1; tick(3); snd_rd = 1'b0; tick(1);
    total++; if (snd_full !== 1'b0) begin bad++; $display("FAIL collide_consume got=%b exp=0", snd_full); end
  endtask

  task automatic test_ctrl();
    logic [7:0] dat [4];
    logic [2:0] exp_c [4];
    dat   = '{8'h07, 8'h00, 8'h05, 8'hF8};
    exp_c = '{3'b111, 3'b000, 3'b101, 3'b000};
    for (int i = 0; i < 4; i++) begin
      io_write(16'h0011, dat[i]);
      total++; if ({flip, coin_cnt1, coin_cnt2} !== exp_c[i]) begin bad++; $display("FAIL ctrl_%h got=%b exp=%b", dat[i], {flip, coin_cnt1, coin_cnt2}, exp_c[i]); end
    end
    io_write(16'h0011, 8'h02);
    io_write(16'h0013, 8'hFF);
    total++; if ({flip, coin_cnt1, coin_cnt2, snd_full} !== 4'b0100) begin bad++; $display("FAIL unmapped_write got=%b exp=0100", {flip, coin_cnt1, coin_cnt2, snd_full}); end
  endtask

  task automatic test_wdog();
    logic [7:0] d; logic s; int hi;
`ifdef MCPU_IOMAP_WDOG_EN
    vb_pulse(); vb_pulse();
    vb = 1'b1;
    hi = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (wdog_reset === 1'b1) hi++;
      if (i == 3) vb = 1'b0;
    end
    total++; if (hi !== 32) begin bad++; $display("FAIL wdog_pulse_len got=%0d exp=32", hi); end
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL wdog_status got=%h exp=04", d); end
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL wdog_status_clr got=%h exp=00", d); end
    vb_pulse(); vb_pulse();
    io_write(16'h0012, 8'h00);
    hi = 0;
    vb = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (wdog_reset === 1'b1) hi++;
      if (i == 3) vb = 1'b0;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL wdog_kick got=%0d exp=0", hi); end
    io_write(16'h0012, 8'h00);
`else
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      vb = 1'b1; tick(2);
      if (wdog_reset === 1'b1) hi++;
      vb = 1'b0; tick(2);
      if (wdog_reset === 1'b1) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL wdog_disabled got=%0d exp=0", hi); end
    io_write(16'h0012, 8'hFF);
    io_read(16'h0005, d, s);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL wdog_disabled_status got=%h exp=00", d); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    p1 = 8'hFF; p2 = 8'hFF; system = 8'hFF; dsw1 = 8'hFF; dsw2 = 8'hFF;
    test_reset();
    test_read_map();
    test_snd_latch();
    test_overrun();
    test_collision();
    test_ctrl();
    test_wdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu_iomap.md
# mcpu_iomap

Z80 I/O-space decoder for the main CPU, directly downstream of the main CPU wrapper. It consumes the decoded strobes (`mcpu_io`, `mcpu_rd`, `mcpu_wr`, `mcpu_m1`), address and write data, and returns I/O read data for the CPU data-in mux. It also owns the main-to-sound command latch with its handshake, the control register (flip and coin counters), and a frame-based watchdog.

## Interface
Parameters:
- `WDOG_FRAMES`, 8'd60: vblank rising edges without a kick before the watchdog fires (1..255).
- `WDOG_RST_LEN`, 8'd32: clk_sys cycles that `wdog_reset` stays high (1..255).

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mcpu_ab` in 16: CPU address; only [7:0] is decoded.
- `mcpu_dout` in 8: CPU write data.
- `mcpu_wr`, `mcpu_rd`, `mcpu_io`, `mcpu_m1` in 1 each: active-high CPU strobes.
- `vb` in 1: vertical blank.
- `p1`, `p2`, `system`, `dsw1`, `dsw2` in 8 each: active-low inputs, passed through unmodified.
- `io_dout` out 8: read data for the CPU mux.
- `io_sel` out 1: high while an I/O read cycle is active.
- `snd_latch` out 8: sound command byte.
- `snd_full` out 1: latch holds an unread command; also the sound CPU interrupt.
- `snd_rd` in 1: sound side consumed the latch; level, edge-detected.
- `flip`, `coin_cnt1`, `coin_cnt2` out 1 each: control register bits.
- `wdog_reset` out 1: active-high reset request to the top level.

## Operation
- I/O cycle qualifier: `ioc = mcpu_io & ~mcpu_m1`. Interrupt-acknowledge cycles (io & m1) are never decoded.
- Read map, on `mcpu_ab[7:0]`:
  - 0x00 `p1`, 0x01 `p2`, 0x02 `system`, 0x03 `dsw1`, 0x04 `dsw2`.
  - 0x05 status: {5'b0, `wdog_fired`, `overrun`, `snd_full`}.
  - Any other address reads 0xFF.
- Write map:
  - 0x10: sound latch.
  - 0x11: control register. bit0 → `flip`, bit1 → `coin_cnt1`, bit2 → `coin_cnt2`; other bits are ignored.
  - 0x12: watchdog kick; data is ignored.
  - Other addresses: no effect.
- Write strobe: a one-cycle pulse on the rising edge of `ioc & mcpu_wr`. Data is sampled from `mcpu_dout` on the strobe cycle.
- Status-read strobe: a one-cycle pulse on the rising edge of `ioc & mcpu_rd` with address 0x05.
- Sound latch:
  - Write 0x10 loads `snd_latch` and sets `snd_full`.
  - If `snd_full` was already 1, the latch is still overwritten and sticky `overrun` is set.
  - A rising edge of `snd_rd` clears `snd_full`.
  - Write and `snd_rd` edge in the same cycle: the write wins, `snd_full` stays 1, and `overrun` is not set.
  - A status-read strobe clears `overrun` and `wdog_fired` after the current read value has been returned.
- Watchdog: see Configuration.

## Timing
- Reset values of all outputs and state:
  - `io_dout` = 0xFF.
  - `io_sel`, `snd_latch`, `snd_full`, `flip`, `coin_cnt1`, `coin_cnt2`, `wdog_reset` = 0.
  - `overrun`, `wdog_fired`, watchdog counter = 0.
  - All edge-detect registers = 0.
- `io_sel` is registered: it follows `ioc & mcpu_rd` with 1 cycle of latency.
- `io_dout` is registered: it updates every cycle while `ioc & mcpu_rd`, otherwise it holds.
  - Latency is 1 clk_sys, which is well inside one CPU cen period (16 clocks).
- Register effects from a write are visible 1 cycle after the strobe, i.e. 2 cycles after `mcpu_wr` rises.
- `snd_full` falls 2 cycles after `snd_rd` rises: 1 cycle of edge detect plus 1 cycle of update.
- Reset is allowed mid-cycle. After `reset_n` deasserts, a `mcpu_wr` that is already high produces no strobe until it goes low and then high again.

## Configuration
- Macro `MCPU_IOMAP_WDOG_EN` defined, watchdog present:
  - An 8-bit counter increments on each rising edge of `vb` and clears on a kick (write to 0x12).
  - A kick and a vb edge in the same cycle: the counter clears.
  - When the counter reaches `WDOG_FRAMES`: the counter clears, `wdog_fired` is set, and `wdog_reset` goes high for exactly `WDOG_RST_LEN` cycles.
  - vb edges during the reset pulse are ignored.
- Macro not defined:
  - `wdog_reset` and `wdog_fired` are tied to 0.
  - Writes to 0x12 are ignored; the status bit2 reads 0.

## Test plan
- Reset, then I/O reads of 0x00..0x05 and 0x7F with `p1`=0xFE, `dsw2`=0x3C → returns 0xFE, …, 0x3C, status 0x00, and 0xFF for 0x7F; with `mcpu_m1`=1 and io high, `io_sel` stays 0.
- Write 0x10 with data 0x5A → `snd_latch`=0x5A and `snd_full`=1; pulse `snd_rd` → `snd_full`=0 two cycles later.
- Two writes to 0x10 (0x01, then 0x02) with no `snd_rd` → `snd_latch`=0x02; status reads 0x03, then a second read returns 0x01.
- Write 0x10 in the same cycle as a `snd_rd` edge → `snd_full`=1 and `overrun`=0.
- Write 0x07 to port 0x11 → `flip`=1, `coin_cnt1`=1, `coin_cnt2`=1; a write of 0x00 clears all three.
- `WDOG_EN` build, `WDOG_FRAMES`=3:
  - Three vb edges with no kick → `wdog_reset` high for exactly 32 cycles, and the status read returns 0x04.
  - A kick between edges 2 and 3 → no reset.
  - A build without the macro → `wdog_reset` is never asserted.
